serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl_pkg.sv | 11 +
 rtl/serial_adder_ctrl_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 110 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
// Holds the FSM state encoding used by serial_adder_ctrl.
package serial_adder_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/serial_adder_ctrl_adder.sv
// One-bit full adder cell; the controller reuses this cell once per operand bit.
module single_bit_adder (
   input  logic c_in,
   input  logic a,
   input  logic b,
   output logic sum,
   output logic c_out
);

   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: steps one full-adder cell over WIDTH-bit
// operands LSB first and publishes sum/c_out/ovf in registers when finished.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] sum_q;
   logic             carry;
   logic             c_out_q;
   logic             ovf_q;
   logic             bit_sum;
   logic             bit_cout;
   logic             last_bit;

   single_bit_adder u_adder (
      .c_in  (carry),
      .a     (op_a[0]),
      .b     (op_b[0]),
      .sum   (bit_sum),
      .c_out (bit_cout)
   );

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (last_bit) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         op_a    <= '0;
         op_b    <= '0;
         res     <= '0;
         carry   <= 1'b0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
                  op_a  <= a;
                  op_b  <= sub ? ~b : b;
                  carry <= sub;
                  cnt   <= '0;
               end
            end
            RUN: begin
               op_a  <= op_a >> 1;
               op_b  <= op_b >> 1;
               res   <= {bit_sum, res[WIDTH-1:1]};
               carry <= bit_cout;
               cnt   <= cnt + CNT_W'(1);
               if (last_bit) begin
                  // carry here is the carry into the MSB, so xor with carry out gives signed overflow.
                  sum_q   <= {bit_sum, res[WIDTH-1:1]};
                  c_out_q <= bit_cout;
                  ovf_q   <= carry ^ bit_cout;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy  = (state != IDLE);
   assign done  = (state == DONE);
   assign sum   = sum_q;
   assign c_out = c_out_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed and random operations,
// expected results queued at issue time and compared by an independent monitor.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         c_out;
   logic         ovf;

   int           n_checks = 0;
   int           n_fail = 0;
   int           cyc = 0;
   logic [W+1:0] exp_q[$];
   int           cyc_q[$];
   logic [W+1:0] held = '0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .c_out (c_out),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference result {sum, c_out, ovf} from plain integer arithmetic.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
      int   ux, uy, sx, sy, r, sr;
      logic co, ov;
      ux = int'(x);
      uy = int'(y);
      sx = x[W-1] ? ux - (1 << W) : ux;
      sy = y[W-1] ? uy - (1 << W) : uy;
      if (!s) begin
         r  = ux + uy;
         co = (r >= (1 << W));
         sr = sx + sy;
      end else begin
         r  = ux - uy;
         co = (ux >= uy);
         sr = sx - sy;
      end
      ov = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
      return {r[W-1:0], co, ov};
   endfunction

   // Called in the phase just after a rising edge.
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("idle_wait", 32'(busy), 32'd0);
   endtask

   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      wait_idle();
      a     = x;
      b     = y;
      sub   = s;
      start = 1'b1;
      exp_q.push_back(model(x, y, s));
      cyc_q.push_back(cyc + 1);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("start_accepted", 32'(busy), 32'd1);
   endtask

   // Monitor: pops one expectation per done pulse; otherwise outputs must hold.
   initial begin
      logic [W+1:0] e;
      int           st;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (done) begin
               if (exp_q.size() == 0) begin
                  check("done_unexpected", 32'(done), 32'd0);
               end else begin
                  e  = exp_q.pop_front();
                  st = cyc_q.pop_front();
                  check("result", 32'({sum, c_out, ovf}), 32'(e));
                  check("latency", 32'(cyc - st), 32'(W));
                  check("busy_in_done", 32'(busy), 32'd1);
                  held = e;
               end
            end else begin
               check("output_hold", 32'({sum, c_out, ovf}), 32'(held));
            end
         end
      end
   end

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_outputs", 32'({sum, c_out, ovf}), 32'd0);

      issue(8'h3C, 8'h05, 1'b0);
      issue(8'hFF, 8'h01, 1'b0);
      issue(8'h7F, 8'h01, 1'b0);
      issue(8'h05, 8'h07, 1'b1);
      issue(8'h80, 8'h01, 1'b1);

      // Starts and operand changes during RUN must be ignored.
      issue(8'h10, 8'h20, 1'b0);
      for (int i = 0; i < 6; i++) begin
         start = 1'b1;
         a     = 8'hAA;
         b     = 8'h55;
         sub   = ~sub;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      issue(8'h11, 8'h22, 1'b1);

      // Abort mid-run: reset on the 4th RUN edge, with a competing start.
      wait_idle();
      a     = 8'h5A;
      b     = 8'h33;
      sub   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      held  = '0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_outputs", 32'({sum, c_out, ovf}), 32'd0);
      issue(8'h01, 8'h01, 1'b0);

      for (int i = 0; i < 40; i++) begin
         issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
